// File: rtl/coin_pkg.sv
// Shared definitions for the coin payout block: coin indices, BCD coin values,
// FSM state encoding and the BCD digit check.
package coin_pkg;

    localparam int NUM_COINS = 5;

    localparam logic [2:0] COIN_005 = 3'd0;
    localparam logic [2:0] COIN_010 = 3'd1;
    localparam logic [2:0] COIN_020 = 3'd2;
    localparam logic [2:0] COIN_050 = 3'd3;
    localparam logic [2:0] COIN_100 = 3'd4;

    localparam logic [11:0] VAL_005 = 12'h005;
    localparam logic [11:0] VAL_010 = 12'h010;
    localparam logic [11:0] VAL_020 = 12'h020;
    localparam logic [11:0] VAL_050 = 12'h050;
    localparam logic [11:0] VAL_100 = 12'h100;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_SELECT = 3'd2;
    localparam logic [2:0] ST_PULSE  = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    function automatic logic [11:0] coin_value(input logic [2:0] k);
        logic [11:0] v;
        case (k)
            COIN_005: v = VAL_005;
            COIN_010: v = VAL_010;
            COIN_020: v = VAL_020;
            COIN_050: v = VAL_050;
            COIN_100: v = VAL_100;
            default:  v = 12'h000;
        endcase
        return v;
    endfunction

    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/coin_payout_bcd_sub.sv
// Combinational packed-BCD subtractor, a - b, ripple borrow across all digits.
module bcd_sub #(
    parameter int DIGITS = 8
) (
    input  logic [4*DIGITS-1:0] i_a,
    input  logic [4*DIGITS-1:0] i_b,
    output logic [4*DIGITS-1:0] o_diff
);

    logic       w_borrow;
    logic [4:0] w_dig;

    always_comb begin
        w_borrow = 1'b0;
        w_dig    = 5'd0;
        o_diff   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig    = {1'b0, i_a[4*i +: 4]} - {1'b0, i_b[4*i +: 4]} - {4'b0, w_borrow};
            w_borrow = w_dig[4];
            // a negative digit wraps mod 32; adding ten restores the BCD digit
            if (w_borrow) begin
                w_dig = w_dig + 5'd10;
            end
            o_diff[4*i +: 4] = w_dig[3:0];
        end
    end

endmodule

// File: rtl/coin_payout.sv
// Greedy change dispenser: pays a packed-BCD balance through five hopper
// solenoids and reports the unpaid remainder.
module coin_payout #(
    parameter int DIGITS       = 8,
    parameter int PULSE_CYCLES = 2_500_000,
    parameter int GAP_CYCLES   = 5_000_000
) (
    input  logic                CLK_50,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] amount,
    input  logic [4:0]          empty,
    output logic [4:0]          eject,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [4*DIGITS-1:0] remaining
);
    import coin_pkg::*;

    localparam int W       = 4 * DIGITS;
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_coin;
    logic [4:0]       r_eject;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [W-1:0]     r_remaining;

    logic             w_amt_valid;
    logic             w_pick_ok;
    logic [2:0]       w_pick;
    logic [W-1:0]     w_coin_val;
    logic [W-1:0]     w_sub_res;

    always_comb begin
        w_amt_valid = (r_remaining[3:0] == 4'h0) || (r_remaining[3:0] == 4'h5);
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_ok(r_remaining[4*i +: 4])) begin
                w_amt_valid = 1'b0;
            end
        end
    end

    // Ascending scan so the last qualifying coin, the largest, wins.
    always_comb begin
        w_pick_ok = 1'b0;
        w_pick    = COIN_005;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (!empty[k] && (W'(coin_value(3'(k))) <= r_remaining)) begin
                w_pick_ok = 1'b1;
                w_pick    = 3'(k);
            end
        end
    end

    assign w_coin_val = W'(coin_value(r_coin));

    bcd_sub #(
        .DIGITS(DIGITS)
    ) u_sub (
        .i_a   (r_remaining),
        .i_b   (w_coin_val),
        .o_diff(w_sub_res)
    );

    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_coin      <= COIN_005;
            r_eject     <= 5'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining <= amount;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_amt_valid) begin
                        r_state <= ST_SELECT;
                    end else begin
                        r_err       <= 1'b1;
                        r_remaining <= '0;
                        r_done      <= 1'b1;
                        r_state     <= ST_FIN;
                    end
                end
                ST_SELECT: begin
                    r_cnt <= '0;
                    if (r_remaining == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else if (w_pick_ok) begin
                        r_coin  <= w_pick;
                        r_eject <= 5'(1) << w_pick;
                        r_state <= ST_PULSE;
                    end else begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
                end
                ST_PULSE: begin
                    // The balance is debited on the same edge the solenoid drops.
                    if (r_cnt == PULSE_LAST) begin
                        r_eject     <= 5'b0;
                        r_remaining <= w_sub_res;
                        r_cnt       <= '0;
                        r_state     <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_SELECT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_eject <= 5'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign eject     = r_eject;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign remaining = r_remaining;

endmodule
